// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for two cache ports sharing one block-wide memory port.
// Each grant issues one read or write strobe, waits out the read latency, and pulses ack.
module mem_arbiter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MWIDTH      = 64,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [WIDTH-1:0]  addr0,
    input  logic [WIDTH-1:0]  addr1,
    input  logic [MWIDTH-1:0] wdata0,
    input  logic [MWIDTH-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [MWIDTH-1:0] rdata0,
    output logic [MWIDTH-1:0] rdata1,
    output logic [WIDTH-1:0]  mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [MWIDTH-1:0] mem_din,
    input  logic [MWIDTH-1:0] mem_q,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [3:0] LatCount = 4'(MEM_LATENCY);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               port_q, port_d;
    logic               we_q, we_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [MWIDTH-1:0]  mem_din_q, mem_din_d;
    logic               mem_rden_q, mem_rden_d;
    logic               mem_wren_q, mem_wren_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic [MWIDTH-1:0]  rdata0_q, rdata0_d;
    logic [MWIDTH-1:0]  rdata1_q, rdata1_d;
    logic               busy_q, busy_d;

    logic               grant_port;
    logic               sel_we;
    logic [WIDTH-1:0]   sel_addr;
    logic [MWIDTH-1:0]  sel_wdata;

    // On a tie the port that did not win last time is chosen; otherwise the lone requester.
    always_comb begin
        if (req0 && req1) begin
            grant_port = ~last_grant_q;
        end else begin
            grant_port = req1;
        end
        sel_we    = grant_port ? we1 : we0;
        sel_addr  = grant_port ? addr1 : addr0;
        sel_wdata = grant_port ? wdata1 : wdata0;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_rden_d   = 1'b0;
        mem_wren_d   = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            StIdle: begin
                // Strobes are registered here so they are high during the ISSUE cycle.
                if (req0 || req1) begin
                    state_d      = StIssue;
                    last_grant_d = grant_port;
                    port_d       = grant_port;
                    we_d         = sel_we;
                    mem_addr_d   = sel_addr;
                    mem_rden_d   = ~sel_we;
                    mem_wren_d   = sel_we;
                    if (sel_we) begin
                        mem_din_d = sel_wdata;
                    end
                end
            end
            StIssue: begin
                if (we_q) begin
                    state_d = StResp;
                    ack0_d  = ~port_q;
                    ack1_d  = port_q;
                end else begin
                    state_d = StWait;
                    cnt_d   = LatCount;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    ack0_d  = ~port_q;
                    ack1_d  = port_q;
                    if (port_q) begin
                        rdata1_d = mem_q;
                    end else begin
                        rdata0_d = mem_q;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= 4'd0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_rden_q   <= 1'b0;
            mem_wren_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_rden_q   <= mem_rden_d;
            mem_wren_q   <= mem_wren_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign mem_addr = mem_addr_q;
    assign mem_rden = mem_rden_q;
    assign mem_wren = mem_wren_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (latency 2, 1, 7) each with a
// memory model whose read data is valid only in the cycle rden + latency.
module tb_mem_arbiter;

    localparam int unsigned LatA = 2;
    localparam int unsigned LatB = 1;
    localparam int unsigned LatC = 7;
    localparam logic [63:0] Poison = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [63:0] wdata0 = '0, wdata1 = '0;
    logic        req0_b = 1'b0, req0_c = 1'b0;

    logic        ack0, ack1, mem_rden, mem_wren, busy;
    logic [63:0] rdata0, rdata1, mem_din, mem_q;
    logic [31:0] mem_addr;
    logic        ack0_b, ack1_b, mem_rden_b, mem_wren_b, busy_b;
    logic [63:0] rdata0_b, rdata1_b, mem_din_b, mem_q_b;
    logic [31:0] mem_addr_b;
    logic        ack0_c, ack1_c, mem_rden_c, mem_wren_c, busy_c;
    logic [63:0] rdata0_c, rdata1_c, mem_din_c, mem_q_c;
    logic [31:0] mem_addr_c;

    int checks = 0;
    int failures = 0;

    logic [4:0] ctrl;
    assign ctrl = {ack0, ack1, mem_rden, mem_wren, busy};

    always #5 clock = ~clock;

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        if (a == 32'h100) return 64'hDEADBEEF_CAFEF00D;
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    logic [7:0]  va = '0, vb = '0, vc = '0;
    logic [31:0] pa [8];
    logic [31:0] pb [8];
    logic [31:0] pc [8];

    always @(posedge clock) begin
        va <= {va[6:0], mem_rden};
        vb <= {vb[6:0], mem_rden_b};
        vc <= {vc[6:0], mem_rden_c};
        pa[0] <= mem_addr;
        pb[0] <= mem_addr_b;
        pc[0] <= mem_addr_c;
        for (int i = 1; i < 8; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
            pc[i] <= pc[i-1];
        end
    end

    assign mem_q   = va[LatA-1] ? mem_data(pa[LatA-1]) : Poison;
    assign mem_q_b = vb[LatB-1] ? mem_data(pb[LatB-1]) : Poison;
    assign mem_q_c = vc[LatC-1] ? mem_data(pc[LatC-1]) : Poison;

    mem_arbiter #(.WIDTH(32), .MWIDTH(64), .MEM_LATENCY(LatA)) u_dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_din(mem_din), .mem_q(mem_q), .busy(busy)
    );

    mem_arbiter #(.WIDTH(32), .MWIDTH(64), .MEM_LATENCY(LatB)) u_dut_b (
        .clock(clock), .reset(reset),
        .req0(req0_b), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(addr0), .addr1(32'h0), .wdata0(64'h0), .wdata1(64'h0),
        .ack0(ack0_b), .ack1(ack1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
        .mem_addr(mem_addr_b), .mem_rden(mem_rden_b), .mem_wren(mem_wren_b),
        .mem_din(mem_din_b), .mem_q(mem_q_b), .busy(busy_b)
    );

    mem_arbiter #(.WIDTH(32), .MWIDTH(64), .MEM_LATENCY(LatC)) u_dut_c (
        .clock(clock), .reset(reset),
        .req0(req0_c), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(addr0), .addr1(32'h0), .wdata0(64'h0), .wdata1(64'h0),
        .ack0(ack0_c), .ack1(ack1_c), .rdata0(rdata0_c), .rdata1(rdata1_c),
        .mem_addr(mem_addr_c), .mem_rden(mem_rden_c), .mem_wren(mem_wren_c),
        .mem_din(mem_din_c), .mem_q(mem_q_c), .busy(busy_c)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++;
        if (ctrl !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", ctrl);
        end
        checks++;
        if ({rdata0, rdata1} !== 128'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h %h want=0", rdata0, rdata1);
        end
        checks++;
        if ({mem_addr, mem_din} !== 96'h0) begin
            failures++;
            $display("FAIL reset_mem got addr=%h din=%h want=0", mem_addr, mem_din);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (ctrl !== 5'b0) begin
            failures++;
            $display("FAIL idle_ctrl got=%b want=00000", ctrl);
        end
    endtask

    task automatic test_reset_mid_read;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
        tick;
        checks++;
        if (ctrl !== 5'b00101 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL mid_issue got ctrl=%b addr=%h want=00101 100", ctrl, mem_addr);
        end
        tick;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b0 || rdata0 !== 64'h0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got ctrl=%b rdata0=%h addr=%h want=0", ctrl, rdata0, mem_addr);
        end
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2A0; wdata1 = 64'h99;
        tick;
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            logic [4:0] exp;
            tick;
            exp = (c == 1) ? 5'b00101 : (c == 4) ? 5'b10001 : (c == 5) ? 5'b00000 : 5'b00001;
            checks++;
            if (ctrl !== exp) begin
                failures++;
                $display("FAIL post_reset_ctrl c=%0d got=%b want=%b", c, ctrl, exp);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 32'h100) begin
                    failures++;
                    $display("FAIL post_reset_tie got addr=%h want=100", mem_addr);
                end
            end
            if (c == 4) begin
                checks++;
                if (rdata0 !== 64'hDEADBEEF_CAFEF00D) begin
                    failures++;
                    $display("FAIL post_reset_rdata got=%h want=deadbeefcafef00d", rdata0);
                end
                req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
            end
        end
    endtask

    task automatic test_single_read;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h180;
        for (int c = 1; c <= 5; c++) begin
            logic [4:0] exp;
            tick;
            exp = (c == 1) ? 5'b00101 : (c == 4) ? 5'b10001 : (c == 5) ? 5'b00000 : 5'b00001;
            checks++;
            if (ctrl !== exp) begin
                failures++;
                $display("FAIL read_ctrl c=%0d got=%b want=%b", c, ctrl, exp);
            end
            if (c == 3) begin
                checks++;
                if (rdata0 !== 64'hDEADBEEF_CAFEF00D) begin
                    failures++;
                    $display("FAIL read_early got=%h want=deadbeefcafef00d", rdata0);
                end
            end
            if (c == 4) begin
                checks++;
                if (rdata0 !== mem_data(32'h180)) begin
                    failures++;
                    $display("FAIL read_data got=%h want=%h", rdata0, mem_data(32'h180));
                end
                req0 = 1'b0;
            end
        end
    endtask

    task automatic test_dirty_miss;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 64'h77;
        for (int c = 1; c <= 8; c++) begin
            logic [4:0] exp;
            tick;
            case (c)
                1: exp = 5'b00011;
                2: exp = 5'b01001;
                3: exp = 5'b00000;
                4: exp = 5'b00101;
                7: exp = 5'b01001;
                8: exp = 5'b00000;
                default: exp = 5'b00001;
            endcase
            checks++;
            if (ctrl !== exp) begin
                failures++;
                $display("FAIL dirty_ctrl c=%0d got=%b want=%b", c, ctrl, exp);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 32'h40 || mem_din !== 64'h77) begin
                    failures++;
                    $display("FAIL dirty_wr got addr=%h din=%h want=40 77", mem_addr, mem_din);
                end
            end
            if (c == 2) begin
                we1 = 1'b0; addr1 = 32'h80;
            end
            if (c == 4) begin
                checks++;
                if (mem_addr !== 32'h80) begin
                    failures++;
                    $display("FAIL dirty_rd_addr got=%h want=80", mem_addr);
                end
            end
            if (c == 7) begin
                checks++;
                if (rdata1 !== mem_data(32'h80)) begin
                    failures++;
                    $display("FAIL dirty_rdata got=%h want=%h", rdata1, mem_data(32'h80));
                end
                req1 = 1'b0;
            end
        end
    endtask

    task automatic test_single_write;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2A0; wdata1 = 64'h1234;
        for (int c = 1; c <= 4; c++) begin
            logic [4:0] exp;
            tick;
            exp = (c == 1) ? 5'b00011 : (c == 2) ? 5'b01001 : 5'b00000;
            checks++;
            if (ctrl !== exp) begin
                failures++;
                $display("FAIL write_ctrl c=%0d got=%b want=%b", c, ctrl, exp);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 32'h2A0 || mem_din !== 64'h1234) begin
                    failures++;
                    $display("FAIL write_mem got addr=%h din=%h want=2a0 1234", mem_addr, mem_din);
                end
            end
            if (c == 2) begin
                checks++;
                if (rdata1 !== mem_data(32'h80)) begin
                    failures++;
                    $display("FAIL write_rdata1 got=%h want=%h", rdata1, mem_data(32'h80));
                end
                req1 = 1'b0; we1 = 1'b0;
            end
        end
        checks++;
        if (mem_din !== 64'h1234 || mem_addr !== 32'h2A0) begin
            failures++;
            $display("FAIL write_hold got addr=%h din=%h want=2a0 1234", mem_addr, mem_din);
        end
    endtask

    task automatic test_simultaneous;
        int  exp_cyc [3] = '{4, 7, 12};
        logic exp_port [3] = '{1'b0, 1'b1, 1'b0};
        int  n = 0;
        logic prev = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2A0; wdata1 = 64'h55;
        for (int c = 1; c <= 14; c++) begin
            tick;
            checks++;
            if ((ack0 && ack1) || (mem_rden && mem_wren) || (prev && (ack0 || ack1))) begin
                failures++;
                $display("FAIL sim_overlap c=%0d got ctrl=%b prev_ack=%b", c, ctrl, prev);
            end
            if (ack0 || ack1) begin
                checks++;
                if (n > 2 || c != exp_cyc[n] || ack1 !== exp_port[n]) begin
                    failures++;
                    $display("FAIL sim_order ack#%0d got cycle=%0d port=%b", n, c, ack1);
                end
                if (ack0) begin
                    checks++;
                    if (rdata0 !== 64'hDEADBEEF_CAFEF00D) begin
                        failures++;
                        $display("FAIL sim_rdata got=%h want=deadbeefcafef00d", rdata0);
                    end
                end
                n++;
            end
            prev = ack0 || ack1;
            if (n == 3) begin
                req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
            end
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL sim_count got=%0d want=3", n);
        end
    endtask

    task automatic test_latency_sweep;
        addr0 = 32'h300;
        req0_b = 1'b1;
        req0_c = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick;
            checks++;
            if ({ack0_b, ack0_c} !== {c == 3, c == 9}) begin
                failures++;
                $display("FAIL sweep_ack c=%0d got=%b%b want=%b%b", c, ack0_b, ack0_c,
                         c == 3, c == 9);
            end
            checks++;
            if ({ack1_b, ack1_c, mem_wren_b, mem_wren_c} !== 4'b0) begin
                failures++;
                $display("FAIL sweep_stray c=%0d got=%b", c,
                         {ack1_b, ack1_c, mem_wren_b, mem_wren_c});
            end
            if (ack0_b) begin
                checks++;
                if (rdata0_b !== mem_data(32'h300)) begin
                    failures++;
                    $display("FAIL sweep_rdata_lat1 got=%h want=%h", rdata0_b, mem_data(32'h300));
                end
                req0_b = 1'b0;
            end
            if (ack0_c) begin
                checks++;
                if (rdata0_c !== mem_data(32'h300)) begin
                    failures++;
                    $display("FAIL sweep_rdata_lat7 got=%h want=%h", rdata0_c, mem_data(32'h300));
                end
                req0_c = 1'b0;
            end
        end
        checks++;
        if ({busy_b, busy_c} !== 2'b0 || {rdata1_b, rdata1_c, mem_din_b, mem_din_c} !== 256'h0) begin
            failures++;
            $display("FAIL sweep_end got busy=%b%b rdata1/din nonzero", busy_b, busy_c);
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid_read;
        test_single_read;
        test_dirty_miss;
        test_single_write;
        test_simultaneous;
        test_latency_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
